div_issue_ctrl: RTL and testbench
=================================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, operand FIFO entries, power of two, minimum 2.
REQ-002 The block SHALL have parameter CW, default log2(DEPTH)+1, occupancy count width.
REQ-003 ck  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  producer offers an operand pair.
REQ-006 in_ready  output  1  FIFO can accept a pair this cycle.
REQ-007 in_n  input  32  dividend, two's complement.
REQ-008 in_d  input  32  divisor, two's complement.
REQ-009 div_n  output  32  dividend driven to the divider.
REQ-010 div_d  output  32  divisor driven to the divider.
REQ-011 div_start  output  1  one-cycle start pulse to the divider.
REQ-012 div_q  input  32  quotient returned by the divider.
REQ-013 div_finished  input  1  divider completion flag.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_q  output  32  quotient result.
REQ-017 out_dz  output  1  divide-by-zero flag for the current result.
REQ-018 busy  output  1  high whenever the state is not IDLE.
REQ-019 level  output  CW  current FIFO occupancy, 0..DEPTH.

Function
REQ-020 The FIFO SHALL be a circular buffer of DEPTH {n,d} entries with log2(DEPTH)-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-021 in_ready SHALL equal (level < DEPTH), computed from registered state only.
REQ-022 A push SHALL occur when in_valid && in_ready; no push when full, and in_n/in_d SHALL be ignored then.
REQ-023 A pop SHALL occur only in IDLE with level > 0; a pair pushed in cycle t SHALL be poppable no earlier than cycle t+1 (no bypass).
REQ-024 Simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-025 The FSM SHALL have states IDLE, ISSUE, WAIT, HOLD.
REQ-026 IDLE, level>0, popped d != 0: load div_n/div_d from the head entry, clear out_dz, go to ISSUE.
REQ-027 IDLE, level>0, popped d == 0: load out_q = 32'hFFFF_FFFF, set out_dz = 1, go to HOLD without pulsing div_start.
REQ-028 IDLE, level == 0: remain in IDLE.
REQ-029 ISSUE: div_start SHALL be 1 for exactly this one cycle; go to WAIT unconditionally.
REQ-030 WAIT: on div_finished = 1, capture div_q into out_q and go to HOLD; otherwise remain in WAIT with no timeout.
REQ-031 div_finished SHALL be ignored in IDLE, ISSUE and HOLD.
REQ-032 div_n/div_d SHALL be registered and held stable from ISSUE until the next load in IDLE.
REQ-033 HOLD: out_valid = 1; out_q/out_dz SHALL be stable until out_ready = 1, then go to IDLE in the next cycle.
REQ-034 out_valid SHALL be 1 only in HOLD.
REQ-035 Minimum issue-to-result latency SHALL be pop cycle + 2 + divider latency; a zero divisor SHALL produce out_valid one cycle after its pop.
REQ-036 Results SHALL leave in the same order the operands were pushed.
REQ-037 Pushes SHALL continue during ISSUE, WAIT and HOLD while in_ready = 1.

Reset
REQ-038 With rst = 1 at a clock edge: state IDLE, pointers 0, level 0, div_start 0, out_valid 0, out_dz 0, out_q 0, div_n 0, div_d 0, busy 0.
REQ-039 Reset mid-operation (any state) SHALL discard FIFO contents and any in-flight result; div_start SHALL NOT assert in the cycle following reset release.
REQ-040 in_ready SHALL be 0 while rst = 1 and 1 in the first cycle after release.

Verification
REQ-041 Push (100,7) with the divider model returning 14 after 10 cycles -> one div_start pulse with div_n = 100, div_d = 7; out_valid with out_q = 14, out_dz = 0.
REQ-042 Push (5,0) -> no div_start; out_valid one cycle after the pop with out_q = 32'hFFFFFFFF, out_dz = 1.
REQ-043 Push 5 pairs back-to-back with the divider stalled -> 4 accepted, in_ready = 0, level = 4; the 5th pair is held off until the first pop.
REQ-044 Hold out_ready = 0 for 20 cycles in HOLD -> out_q stable, no further pops, and pushes still accepted up to full.
REQ-045 Assert rst during WAIT with level = 3 -> next cycle level = 0, out_valid = 0; a late div_finished is ignored.
REQ-046 Push (-9,3),(8,2),(1,0) -> results leave in order with out_dz = 0, 0, 1.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - operand FIFO feeding an external divider, one division in flight
module div_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_n,
    input  logic [31:0]   in_d,
    output logic [31:0]   div_n,
    output logic [31:0]   div_d,
    output logic          div_start,
    input  logic [31:0]   div_q,
    input  logic          div_finished,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_q,
    output logic          out_dz,
    output logic          busy,
    output logic [CW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fifo_n [DEPTH];
    logic [31:0]   fifo_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [31:0]   opn_q, opn_d;
    logic [31:0]   opd_q, opd_d;
    logic [31:0]   res_q, res_d;
    logic          dz_q, dz_d;
    logic          push;
    logic          pop;
    logic [31:0]   head_n;
    logic [31:0]   head_d;

    assign head_n = fifo_n[rd_ptr_q];
    assign head_d = fifo_d[rd_ptr_q];

    // Ready depends only on the occupancy register; it is forced low while reset is held.
    assign in_ready = !rst && (level_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Popping only from IDLE on registered occupancy means a fresh entry is never bypassed.
    assign pop      = (state_q == S_IDLE) && (level_q != '0);

    assign div_n  = opn_q;
    assign div_d  = opd_q;
    assign out_q  = res_q;
    assign out_dz = dz_q;
    assign busy   = (state_q != S_IDLE);
    assign level  = level_q;

    // Next-state logic for the FIFO pointers, occupancy and the issue FSM.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        opn_d     = opn_q;
        opd_d     = opd_q;
        res_d     = res_q;
        dz_d      = dz_q;
        div_start = 1'b0;
        out_valid = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head_d != 32'd0) begin
                        opn_d   = head_n;
                        opd_d   = head_d;
                        dz_d    = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        // Zero divisor never reaches the divider: answer all-ones directly.
                        res_d   = 32'hFFFF_FFFF;
                        dz_d    = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_ISSUE: begin
                div_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (div_finished) begin
                    res_d   = div_q;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers; reset drops queued pairs and any in-flight result.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            opn_q    <= '0;
            opd_q    <= '0;
            res_q    <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            opn_q    <= opn_d;
            opd_q    <= opd_d;
            res_q    <= res_d;
            dz_q     <= dz_d;
        end
    end

    // Operand storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge ck) begin
        if (push) begin
            fifo_n[wr_ptr_q] <= in_n;
            fifo_d[wr_ptr_q] <= in_d;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - randomized and directed bench for div_issue_ctrl
module tb_div_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] d;
    } pair_t;

    logic          ck = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_n;
    logic [31:0]   in_d;
    logic [31:0]   div_n;
    logic [31:0]   div_d;
    logic          div_start;
    logic [31:0]   div_q;
    logic          div_finished;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_q;
    logic          out_dz;
    logic          busy;
    logic [CW-1:0] level;

    int checks   = 0;
    int failures = 0;

    int          div_lat    = 0;
    bit          div_stall  = 1'b0;
    bit          inject_fin = 1'b0;
    bit          dpend      = 1'b0;
    int          dcnt       = 0;
    logic [31:0] dres       = '0;
    int          start_cnt  = 0;

    pair_t mq[$];

    div_issue_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .ck(ck), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_d(in_d),
        .div_n(div_n), .div_d(div_d), .div_start(div_start),
        .div_q(div_q), .div_finished(div_finished),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_dz(out_dz),
        .busy(busy), .level(level)
    );

    always #5 ck = ~ck;

    function automatic logic [31:0] ref_quot(pair_t p);
        if (p.d == 32'd0) return 32'hFFFF_FFFF;
        return 32'($signed(p.n) / $signed(p.d));
    endfunction

    // External divider stand-in: reacts on the falling edge, answers after div_lat cycles.
    initial begin
        div_finished = 1'b0;
        div_q        = '0;
        forever begin
            @(negedge ck);
            div_finished = 1'b0;
            if (rst) begin
                dpend = 1'b0;
            end else begin
                if (inject_fin) begin
                    div_finished = 1'b1;
                    div_q        = 32'h1234_5678;
                end
                if (div_start) begin
                    start_cnt++;
                    dres  = (div_d == 32'd0) ? 32'd0 : 32'($signed(div_n) / $signed(div_d));
                    dcnt  = div_lat;
                    dpend = 1'b1;
                end else if (dpend && !div_stall) begin
                    if (dcnt == 0) begin
                        div_finished = 1'b1;
                        div_q        = dres;
                        dpend        = 1'b0;
                    end else begin
                        dcnt--;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ck);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_n = '0; in_d = '0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready actual=%0b expected=0", in_ready);
        end
        checks++;
        if ({level, busy, out_valid, div_start, out_q, out_dz, div_n, div_d} !== '0) begin
            failures++;
            $display("FAIL reset_state level=%0d busy=%0b ov=%0b ds=%0b q=%h dz=%0b n=%h d=%h expected all 0",
                     level, busy, out_valid, div_start, out_q, out_dz, div_n, div_d);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL release_in_ready actual=%0b expected=1", in_ready);
        end
        tick();
        checks++;
        if (div_start !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL release_idle div_start=%0b busy=%0b expected 0 0", div_start, busy);
        end
    endtask

    task automatic test_basic();
        int starts, start_at, cyc;
        div_lat = 10; div_stall = 1'b0;
        in_valid = 1'b1; in_n = 32'd100; in_d = 32'd7;
        tick();
        in_valid = 1'b0;
        starts = 0; start_at = -1; cyc = 1;
        while (!out_valid && cyc < 100) begin
            if (div_start) begin
                starts++; start_at = cyc;
                checks++;
                if (div_n !== 32'd100 || div_d !== 32'd7) begin
                    failures++; $display("FAIL basic_operands n=%0d d=%0d expected 100 7", div_n, div_d);
                end
            end
            tick(); cyc++;
        end
        checks++;
        if (starts != 1 || start_at != 2) begin
            failures++; $display("FAIL basic_start pulses=%0d at=%0d expected 1 at 2", starts, start_at);
        end
        checks++;
        if (out_valid !== 1'b1 || out_q !== 32'd14 || out_dz !== 1'b0) begin
            failures++; $display("FAIL basic_result ov=%0b q=%0d dz=%0b expected 1 14 0", out_valid, out_q, out_dz);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_consume ov=%0b busy=%0b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_div_zero();
        int s0;
        s0 = start_cnt;
        in_valid = 1'b1; in_n = 32'd5; in_d = 32'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL dz_pop_cycle level=%0d ov=%0b expected 1 0", level, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_q !== 32'hFFFF_FFFF || out_dz !== 1'b1) begin
            failures++; $display("FAIL dz_result ov=%0b q=%h dz=%0b expected 1 ffffffff 1", out_valid, out_q, out_dz);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (start_cnt != s0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL dz_no_start starts=%0d ov=%0b expected %0d 0", start_cnt, out_valid, s0);
        end
    endtask

    task automatic test_full();
        pair_t pr[5];
        pair_t p;
        int acc, outs, cyc;
        bit clr;
        div_stall = 1'b1; div_lat = 0; out_ready = 1'b0;
        p.n = 32'd1000; p.d = 32'd10; mq.push_back(p);
        in_valid = 1'b1; in_n = p.n; in_d = p.d;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || level !== 3'd0) begin
            failures++; $display("FAIL full_wait busy=%0b ov=%0b level=%0d expected 1 0 0", busy, out_valid, level);
        end
        for (int i = 0; i < 5; i++) begin
            pr[i].n = 32'(i * 7 + 3); pr[i].d = 32'(i + 2);
        end
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_n = pr[acc].n; in_d = pr[acc].d;
            if (in_ready) begin mq.push_back(pr[acc]); acc++; end
            tick();
        end
        tick(); tick(); tick();
        checks++;
        if (acc != 4 || level !== 3'd4 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_limit accepted=%0d level=%0d ready=%0b expected 4 4 0", acc, level, in_ready);
        end
        div_stall = 1'b0; out_ready = 1'b1; outs = 0; cyc = 0; clr = 1'b0;
        while (mq.size() > 0 && cyc < 200) begin
            if (in_valid && in_ready) begin
                checks++;
                if (outs < 1 || level !== 3'd3) begin
                    failures++; $display("FAIL full_fifth_early outs=%0d level=%0d expected >=1 3", outs, level);
                end
                mq.push_back(pr[4]); acc++; clr = 1'b1;
            end
            if (out_valid) begin
                checks++;
                if (out_q !== ref_quot(mq[0]) || out_dz !== (mq[0].d == 32'd0)) begin
                    failures++; $display("FAIL full_result q=%h dz=%0b expected %h %0b", out_q, out_dz, ref_quot(mq[0]), mq[0].d == 32'd0);
                end
                void'(mq.pop_front()); outs++;
            end
            tick(); cyc++;
            if (clr) begin in_valid = 1'b0; clr = 1'b0; end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (mq.size() != 0 || acc != 5 || outs != 6) begin
            failures++; $display("FAIL full_drain left=%0d accepted=%0d outs=%0d expected 0 5 6", mq.size(), acc, outs);
        end
    endtask

    task automatic test_hold_stall();
        pair_t p;
        logic [31:0] hq;
        int lvl, cyc;
        div_stall = 1'b0; div_lat = 2; out_ready = 1'b0;
        p.n = 32'd20; p.d = 32'd4; mq.push_back(p);
        in_valid = 1'b1; in_n = p.n; in_d = p.d;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin tick(); cyc++; end
        hq = out_q;
        checks++;
        if (out_valid !== 1'b1 || hq !== 32'd5) begin
            failures++; $display("FAIL hold_first ov=%0b q=%0d expected 1 5", out_valid, hq);
        end
        lvl = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; in_n = $urandom; in_d = $urandom_range(1, 50);
            if (in_ready) begin p.n = in_n; p.d = in_d; mq.push_back(p); lvl++; end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_q !== hq || level !== CW'(lvl)) begin
                failures++; $display("FAIL hold_stable ov=%0b q=%h level=%0d expected 1 %h %0d", out_valid, out_q, level, hq, lvl);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (lvl != DEPTH || in_ready !== 1'b0) begin
            failures++; $display("FAIL hold_fill pushed=%0d ready=%0b expected 4 0", lvl, in_ready);
        end
        out_ready = 1'b1; cyc = 0;
        while (mq.size() > 0 && cyc < 200) begin
            if (out_valid) begin
                checks++;
                if (out_q !== ref_quot(mq[0]) || out_dz !== (mq[0].d == 32'd0)) begin
                    failures++; $display("FAIL hold_result q=%h dz=%0b expected %h %0b", out_q, out_dz, ref_quot(mq[0]), mq[0].d == 32'd0);
                end
                void'(mq.pop_front());
            end
            tick(); cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (mq.size() != 0) begin
            failures++; $display("FAIL hold_drain left=%0d expected 0", mq.size());
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        div_stall = 1'b1; div_lat = 0; out_ready = 1'b0;
        s0 = start_cnt;
        in_valid = 1'b1; in_n = 32'd77; in_d = 32'd7;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_n = 32'(i + 1); in_d = 32'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (level !== 3'd3 || busy !== 1'b1 || out_valid !== 1'b0 || start_cnt != s0 + 1) begin
            failures++; $display("FAIL rmid_setup level=%0d busy=%0b ov=%0b starts=%0d expected 3 1 0 %0d", level, busy, out_valid, start_cnt - s0, 1);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL rmid_reset level=%0d ov=%0b busy=%0b ready=%0b expected 0 0 0 0", level, out_valid, busy, in_ready);
        end
        rst = 1'b0; div_stall = 1'b0;
        tick();
        checks++;
        if (div_start !== 1'b0 || level !== 3'd0) begin
            failures++; $display("FAIL rmid_release div_start=%0b level=%0d expected 0 0", div_start, level);
        end
        inject_fin = 1'b1;
        tick();
        inject_fin = 1'b0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || start_cnt != s0 + 1) begin
            failures++; $display("FAIL rmid_late_finish ov=%0b busy=%0b starts=%0d expected 0 0 1", out_valid, busy, start_cnt - s0);
        end
        mq.delete();
    endtask

    task automatic test_order();
        logic [31:0] pn[3], pd[3], eq[3];
        logic        edz[3];
        int idx, cyc, s0;
        pn[0] = -32'sd9; pd[0] = 32'd3; eq[0] = 32'hFFFF_FFFD; edz[0] = 1'b0;
        pn[1] = 32'd8;   pd[1] = 32'd2; eq[1] = 32'd4;         edz[1] = 1'b0;
        pn[2] = 32'd1;   pd[2] = 32'd0; eq[2] = 32'hFFFF_FFFF; edz[2] = 1'b1;
        div_lat = 3; div_stall = 1'b0; out_ready = 1'b0;
        s0 = start_cnt;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_n = pn[i]; in_d = pd[i];
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; idx = 0; cyc = 0;
        while (idx < 3 && cyc < 200) begin
            if (out_valid) begin
                checks++;
                if (out_q !== eq[idx] || out_dz !== edz[idx]) begin
                    failures++; $display("FAIL order_result%0d q=%h dz=%0b expected %h %0b", idx, out_q, out_dz, eq[idx], edz[idx]);
                end
                idx++;
            end
            tick(); cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (idx != 3 || start_cnt != s0 + 2) begin
            failures++; $display("FAIL order_count results=%0d starts=%0d expected 3 2", idx, start_cnt - s0);
        end
    endtask

    task automatic test_random();
        pair_t p;
        int cyc;
        div_stall = 1'b0;
        for (cyc = 0; cyc < 900; cyc++) begin
            if (cyc >= 500 && mq.size() == 0) break;
            checks++;
            if (level !== CW'(mq.size() - (busy ? 1 : 0)) || in_ready !== ((mq.size() - (busy ? 1 : 0)) < DEPTH)) begin
                failures++; $display("FAIL rand_level level=%0d ready=%0b queued=%0d busy=%0b", level, in_ready, mq.size(), busy);
            end
            if (div_start) begin
                checks++;
                if (mq.size() == 0 || div_n !== mq[0].n || div_d !== mq[0].d) begin
                    failures++; $display("FAIL rand_issue n=%h d=%h queued=%0d", div_n, div_d, mq.size());
                end
            end
            out_ready = (cyc < 500) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid) begin
                checks++;
                if (mq.size() == 0 || out_q !== ref_quot(mq[0]) || out_dz !== (mq[0].d == 32'd0)) begin
                    failures++; $display("FAIL rand_result q=%h dz=%0b queued=%0d", out_q, out_dz, mq.size());
                end
                if (out_ready && mq.size() > 0) void'(mq.pop_front());
            end
            div_lat  = $urandom_range(0, 6);
            in_valid = (cyc < 500) ? $urandom_range(0, 1) : 1'b0;
            in_n     = $urandom;
            in_d     = ($urandom_range(0, 4) == 0) ? 32'd0 :
                       ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (in_d == 32'hFFFF_FFFF) in_n = in_n >> 1;
            if (in_valid && in_ready) begin p.n = in_n; p.d = in_d; mq.push_back(p); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (mq.size() != 0) begin
            failures++; $display("FAIL rand_drain left=%0d expected 0", mq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_full();
        test_hold_stall();
        test_reset_mid();
        test_order();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
